// File: rtl/ifetch_queue.sv
// Sequential fetch unit: issues PC reads, buffers {pc, inst} in a FIFO for decode, flushes on redirect.
// Optional IFETCH_PERF_EN adds saturating fetched/flushed event counters.
module ifetch_queue #(
  parameter int          XLEN            = 64,
  parameter logic [63:0] RESET_PC        = 64'h8000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic            clock,
  input  logic            reset,
`ifdef IFETCH_PERF_EN
  output logic [31:0]     perf_fetched_o,
  output logic [31:0]     perf_flushed_o,
`endif
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_resp_valid_i,
  input  logic [31:0]     mem_resp_inst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     inst_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_PC);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [31:0]     inst_mem_q [DEPTH];

  logic [PW-1:0]   fifo_count;
  logic [CW-1:0]   live;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;
  logic            unused_tgt_lsb;

  assign unused_tgt_lsb = ^redirect_target_i[1:0];

  // Both channels use strict valid/ready: a transfer happens on a rising clock edge where
  // valid && ready; a raised request holds valid and address until it transfers, except
  // that redirect_i withdraws it. Responses carry no ready: credit guarantees a free slot.
  always_comb begin
    fifo_count      = wr_ptr_q - rd_ptr_q;
    live            = outstanding_q - drop_cnt_q;
    credit_ok       = (SW'(live) + SW'(fifo_count)) < SW'(DEPTH);
    mem_req_valid_o = !reset && !redirect_i && (outstanding_q < CW'(MAX_OUTSTANDING)) && credit_ok;
    mem_req_addr_o  = fetch_pc_q;
    req_fire        = mem_req_valid_o && mem_req_ready_i;
    resp_drop       = mem_resp_valid_i && (redirect_i || (drop_cnt_q != '0));
    push            = mem_resp_valid_i && !resp_drop;
    inst_valid_o    = (fifo_count != '0);
    pop             = inst_valid_o && inst_ready_i && !redirect_i;
    target_pc       = {redirect_target_i[XLEN-1:2], 2'b00};
    pc_o            = inst_valid_o ? pc_mem_q[rd_ptr_q[AW-1:0]]   : '0;
    inst_o          = inst_valid_o ? inst_mem_q[rd_ptr_q[AW-1:0]] : '0;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(mem_resp_valid_i);
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (resp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RST_PC;
      resp_pc_q     <= RST_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[wr_ptr_q[AW-1:0]]   <= resp_pc_q;
      inst_mem_q[wr_ptr_q[AW-1:0]] <= mem_resp_inst_i;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [32:0] fetched_sum, flushed_sum;

  always_comb begin
    fetched_sum    = {1'b0, perf_fetched_q} + 33'(pop);
    flushed_sum    = {1'b0, perf_flushed_q} + (redirect_i ? 33'(fifo_count) : 33'd0) + 33'(resp_drop);
    perf_fetched_d = fetched_sum[32] ? 32'hFFFF_FFFF : fetched_sum[31:0];
    perf_flushed_d = flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_flushed_o = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: 1-cycle memory model, decode scoreboard on an expected-PC queue.
module tb_ifetch_queue;
  localparam int          XLEN   = 64;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i = 1'b0;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_resp_valid_i = 1'b0;
  logic [31:0]     mem_resp_inst_i = '0;
  logic            redirect_i = 1'b0;
  logic [XLEN-1:0] redirect_target_i = '0;
  logic            inst_valid_o;
  logic            inst_ready_i = 1'b0;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     inst_o;
`ifdef IFETCH_PERF_EN
  logic [31:0]     perf_fetched_o;
  logic [31:0]     perf_flushed_o;
`endif

  ifetch_queue dut (
    .clock             (clock),
    .reset             (reset),
`ifdef IFETCH_PERF_EN
    .perf_fetched_o    (perf_fetched_o),
    .perf_flushed_o    (perf_flushed_o),
`endif
    .mem_req_valid_o   (mem_req_valid_o),
    .mem_req_ready_i   (mem_req_ready_i),
    .mem_req_addr_o    (mem_req_addr_o),
    .mem_resp_valid_i  (mem_resp_valid_i),
    .mem_resp_inst_i   (mem_resp_inst_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .pc_o              (pc_o),
    .inst_o            (inst_o)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int              n_checks = 0;
  int              n_err    = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] pend_q[$];
  logic [XLEN-1:0] exp_addr = RST_PC;
  logic            resp_en  = 1'b0;
  int              acc_cnt  = 0;
  int              pop_cnt  = 0;
  logic            s_req_valid;
  logic            s_inst_valid;
  logic [XLEN-1:0] s_req_addr;

  function automatic logic [31:0] inst_of(input logic [XLEN-1:0] pc);
    return pc[31:0] ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic tick();
    logic [XLEN-1:0] a;
    if (resp_en && pend_q.size() > 0) begin
      a = pend_q.pop_front();
      mem_resp_valid_i = 1'b1;
      mem_resp_inst_i  = inst_of(a);
    end else begin
      mem_resp_valid_i = 1'b0;
      mem_resp_inst_i  = '0;
    end
    #4;
    s_req_valid  = mem_req_valid_o;
    s_req_addr   = mem_req_addr_o;
    s_inst_valid = inst_valid_o;
    if (inst_valid_o && inst_ready_i && !redirect_i) begin
      pop_cnt++;
      if (exp_q.size() == 0) check("pop_unexpected", 64'(inst_valid_o), 64'd0);
      else begin
        a = exp_q.pop_front();
        check("pop_pc", pc_o, a);
        check("pop_inst", 64'(inst_o), 64'(inst_of(a)));
      end
    end
    if (redirect_i) exp_q.delete();
    if (mem_req_valid_o && mem_req_ready_i) begin
      acc_cnt++;
      check("req_addr", mem_req_addr_o, exp_addr);
      pend_q.push_back(mem_req_addr_o);
      exp_q.push_back(exp_addr);
      exp_addr = exp_addr + 64'd4;
    end
    if (redirect_i) exp_addr = {redirect_target_i[XLEN-1:2], 2'b00};
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    redirect_i       = 1'b0;
    mem_req_ready_i  = 1'b0;
    inst_ready_i     = 1'b0;
    mem_resp_valid_i = 1'b0;
    resp_en          = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_addr = RST_PC;
    acc_cnt  = 0;
    pop_cnt  = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    @(negedge clock);

    // Streaming: request every cycle, decode sees a PC every cycle from cycle 2.
    do_reset();
    mem_req_ready_i = 1'b1; resp_en = 1'b1; inst_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_req_valid", 64'(s_req_valid), 64'd1);
      check("t1_inst_valid", 64'(s_inst_valid), (k >= 2) ? 64'd1 : 64'd0);
    end
    check("t1_pops", 64'(pop_cnt), 64'd8);

    // Decode stalled: exactly DEPTH requests, then drain in order and resume.
    do_reset();
    mem_req_ready_i = 1'b1; resp_en = 1'b1; inst_ready_i = 1'b0;
    repeat (10) tick();
    check("t2_accepts", 64'(acc_cnt), 64'd4);
    check("t2_req_valid_full", 64'(s_req_valid), 64'd0);
    check("t2_inst_valid", 64'(s_inst_valid), 64'd1);
    inst_ready_i = 1'b1;
    for (int i = 0; i < 20 && acc_cnt < 5; i++) tick();
    check("t2_resume", 64'(acc_cnt), 64'd5);
    repeat (6) tick();

    // Redirect with two reads in flight: both responses dropped.
    do_reset();
    mem_req_ready_i = 1'b1; resp_en = 1'b0; inst_ready_i = 1'b1;
    tick(); tick();
    tick();
    check("t3_max_out", 64'(s_req_valid), 64'd0);
    redirect_i = 1'b1; redirect_target_i = 64'h8000_1002;
    tick();
    check("t3_valid_in_redirect", 64'(s_req_valid), 64'd0);
    redirect_i = 1'b0; resp_en = 1'b1;
    tick();
    check("t3_flushed", 64'(s_inst_valid), 64'd0);
    check("t3_held", 64'(s_req_valid), 64'd0);
    tick();
    check("t3_resume", 64'(s_req_valid), 64'd1);
    check("t3_resume_addr", s_req_addr, 64'h8000_1000);
    repeat (4) tick();
    check("t3_pops", 64'(pop_cnt), 64'd3);

    // Response and redirect in the same cycle with one read outstanding.
    do_reset();
    mem_req_ready_i = 1'b1; resp_en = 1'b0; inst_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; resp_en = 1'b1;
    redirect_i = 1'b1; redirect_target_i = 64'h8000_2000;
    tick();
    redirect_i = 1'b0; mem_req_ready_i = 1'b1;
    tick();
    check("t4_req_valid", 64'(s_req_valid), 64'd1);
    check("t4_req_addr", s_req_addr, 64'h8000_2000);
    repeat (3) tick();
    check("t4_pops", 64'(pop_cnt), 64'd2);

    // Memory stall holds the request; asynchronous reset mid-stall.
    do_reset();
    mem_req_ready_i = 1'b1; resp_en = 1'b1; inst_ready_i = 1'b0;
    tick(); tick();
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_req_valid", 64'(s_req_valid), 64'd1);
      check("t5_req_addr", s_req_addr, 64'h8000_0008);
    end
    check("t5_inst_valid_pre", 64'(s_inst_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("t5_async_inst_valid", 64'(inst_valid_o), 64'd0);
    do_reset();
    mem_req_ready_i = 1'b1;
    tick();
    check("t5_restart", 64'(s_req_valid), 64'd1);
    check("t5_restart_addr", s_req_addr, RST_PC);

`ifdef IFETCH_PERF_EN
    // Ten pops, then redirect with three FIFO entries and one read outstanding.
    do_reset();
    mem_req_ready_i = 1'b1; resp_en = 1'b1; inst_ready_i = 1'b1;
    for (int i = 0; i < 40 && pop_cnt < 10; i++) tick();
    check("t6_pops", 64'(pop_cnt), 64'd10);
    inst_ready_i = 1'b0; mem_req_ready_i = 1'b0; resp_en = 1'b1;
    tick();
    mem_req_ready_i = 1'b1; resp_en = 1'b0;
    tick();
    resp_en = 1'b1;
    tick();
    mem_req_ready_i = 1'b0; resp_en = 1'b0;
    redirect_i = 1'b1; redirect_target_i = 64'h8000_3000;
    tick();
    check("t6_inst_valid_pre", 64'(s_inst_valid), 64'd1);
    redirect_i = 1'b0; resp_en = 1'b1;
    repeat (3) tick();
    check("t6_perf_fetched", 64'(perf_fetched_o), 64'd10);
    check("t6_perf_flushed", 64'(perf_flushed_o), 64'd4);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
